// File: rtl/or1k_exception_vector_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the read-only exception-vector memory.
// Optional idle-owner preemption is compiled in with OR1K_EXCEPTION_VECTOR_ARBITER_TIMEOUT_EN.
module or1k_exception_vector_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [12:0] m0_adr_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  input  logic [12:0] m1_adr_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic [12:0] s_adr_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   ptr_q, ptr_d;     // 0: master 0 preferred, 1: master 1 preferred
  logic   timeout_hit;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must lie in 2..255");
  end

`ifdef OR1K_EXCEPTION_VECTOR_ARBITER_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       owner_idle;

  // Owner holds the bus without strobing while the other master waits.
  always_comb begin
    owner_idle = ((state_q == OWN0) && m0_cyc_i && !m0_stb_i && m1_cyc_i) ||
                 ((state_q == OWN1) && m1_cyc_i && !m1_stb_i && m0_cyc_i);
    timeout_hit = owner_idle && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
    cnt_d = (owner_idle && !timeout_hit) ? cnt_q + 8'd1 : 8'd0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = ptr_q ? OWN1 : OWN0;
        else if (m0_cyc_i)        state_d = OWN0;
        else if (m1_cyc_i)        state_d = OWN1;
      end
      OWN0: begin
        // Hand straight over when the other master is already waiting.
        if (!m0_cyc_i) begin
          state_d = m1_cyc_i ? OWN1 : IDLE;
          ptr_d   = 1'b1;
        end else if (timeout_hit) begin
          state_d = OWN1;
          ptr_d   = 1'b1;
        end
      end
      OWN1: begin
        if (!m1_cyc_i) begin
          state_d = m0_cyc_i ? OWN0 : IDLE;
          ptr_d   = 1'b0;
        end else if (timeout_hit) begin
          state_d = OWN0;
          ptr_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_adr_o  = 13'd0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    grant_o  = 2'b00;
    case (state_q)
      OWN0: begin
        s_adr_o  = m0_adr_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        m0_ack_o = s_ack_i;
        grant_o  = 2'b01;
      end
      OWN1: begin
        s_adr_o  = m1_adr_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        m1_ack_o = s_ack_i;
        grant_o  = 2'b10;
      end
      default: ;
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_or1k_exception_vector_arbiter.sv
// Directed plus random stimulus for the vector-memory arbiter, checked against an owner/turn model.
// Define OR1K_EXCEPTION_VECTOR_ARBITER_TIMEOUT_EN to also model idle-owner preemption.
module tb_or1k_exception_vector_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [12:0] m0_adr_i, m1_adr_i;
  logic        m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m1_ack_o;
  logic [12:0] s_adr_o;
  logic        s_cyc_o, s_stb_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i;
  logic [1:0]  grant_o;

  int compared   = 0;
  int mismatched = 0;

  // Model: owner is -1 (nobody), 0 or 1; pref is whose turn it is when both ask.
  int owner = -1;
  int pref  = 0;
  int idle_run = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [12:0] a);
    return {a, 6'h2A, a ^ 13'h1B5};
  endfunction

  // Vector memory stand-in: combinational data and ack.
  assign s_dat_i = mem_word(s_adr_o);
  assign s_ack_i = s_cyc_o & s_stb_o;

  or1k_exception_vector_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_adr_i(m0_adr_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m1_adr_i(m1_adr_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .s_adr_o(s_adr_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .grant_o(grant_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [1:0]  g;
    logic        c, s, a0, a1;
    logic [12:0] adr;
    g = 2'b00; c = 1'b0; s = 1'b0; adr = 13'd0;
    if (owner == 0) begin g = 2'b01; c = m0_cyc_i; s = m0_stb_i; adr = m0_adr_i; end
    if (owner == 1) begin g = 2'b10; c = m1_cyc_i; s = m1_stb_i; adr = m1_adr_i; end
    a0 = (owner == 0) && c && s;
    a1 = (owner == 1) && c && s;
    chk("grant", 32'(grant_o), 32'(g));
    chk("s_cyc", 32'(s_cyc_o), 32'(c));
    chk("s_stb", 32'(s_stb_o), 32'(s));
    chk("s_adr", 32'(s_adr_o), 32'(adr));
    chk("m0_ack", 32'(m0_ack_o), 32'(a0));
    chk("m1_ack", 32'(m1_ack_o), 32'(a1));
    chk("m0_dat", m0_dat_o, mem_word(adr));
    chk("m1_dat", m1_dat_o, mem_word(adr));
    $display("t=%0t rst=%b cyc=%b%b stb=%b%b grant=%b acks=%b%b s_adr=%h", $time, rst_i,
             m1_cyc_i, m0_cyc_i, m1_stb_i, m0_stb_i, grant_o, m1_ack_o, m0_ack_o, s_adr_o);
  endtask

  task automatic model_update(input logic c0, s0, c1, s1, r);
    logic [1:0] cy, st;
    int other;
    cy = {c1, c0};
    st = {s1, s0};
    if (r) begin
      owner = -1; pref = 0; idle_run = 0;
    end else if (owner < 0) begin
      if (c0 && c1) owner = pref;
      else if (c0)  owner = 0;
      else if (c1)  owner = 1;
      idle_run = 0;
    end else begin
      other = 1 - owner;
      if (!cy[owner]) begin
        owner = cy[other] ? other : -1;
        pref = other;
        idle_run = 0;
      end else begin
`ifdef OR1K_EXCEPTION_VECTOR_ARBITER_TIMEOUT_EN
        if (!st[owner] && cy[other]) begin
          idle_run++;
          if (idle_run == TMO) begin
            owner = other; pref = other; idle_run = 0;
          end
        end else begin
          idle_run = 0;
        end
`else
        idle_run = st[owner] ? 0 : 0;
`endif
      end
    end
  endtask

  task automatic step(input logic c0, input logic s0, input logic [12:0] a0,
                      input logic c1, input logic s1, input logic [12:0] a1, input logic r);
    m0_cyc_i = c0; m0_stb_i = s0; m0_adr_i = a0;
    m1_cyc_i = c1; m1_stb_i = s1; m1_adr_i = a1;
    rst_i = r;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update(c0, s0, c1, s1, r);
    #1;
  endtask

  initial begin
    logic rc0, rc1, rs0, rs1;
    rst_i = 1'b1;
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_adr_i = 13'd0;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_adr_i = 13'd0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, then a single m0 read.
    step(0, 0, 13'h0, 0, 0, 13'h0, 1);
    step(1, 1, 13'h100, 0, 0, 13'h0, 0);
    step(1, 1, 13'h100, 0, 0, 13'h0, 0);
    step(0, 0, 13'h0, 0, 0, 13'h0, 0);

    // Fresh reset, both request together: m0 first, then handover to m1.
    step(0, 0, 13'h0, 0, 0, 13'h0, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 13'(i * 4), 1, 1, 13'h200, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 13'h0, 1, 1, 13'(13'h200 + i * 4), 0);
    step(0, 0, 13'h0, 0, 0, 13'h0, 0);

    // Contention: the owner drops cyc for one cycle, turns must alternate.
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 1) step(owner != 0, owner != 0, 13'h10, owner != 1, owner != 1, 13'h20, 0);
      else            step(1, 1, 13'h10, 1, 1, 13'h20, 0);
    end
    step(0, 0, 13'h0, 0, 0, 13'h0, 0);

    // Reset while m1 owns with stb high; m1 keeps asking and is re-granted.
    step(0, 0, 13'h0, 1, 1, 13'h300, 0);
    step(0, 0, 13'h0, 1, 1, 13'h300, 0);
    step(0, 0, 13'h0, 1, 1, 13'h300, 1);
    step(0, 0, 13'h0, 1, 1, 13'h300, 0);
    step(0, 0, 13'h0, 1, 1, 13'h300, 0);
    step(0, 0, 13'h0, 0, 0, 13'h0, 0);

    // Eight-beat burst from m0.
    step(1, 1, 13'h0, 0, 0, 13'h0, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 13'(i * 4), 0, 0, 13'h0, 0);
    step(0, 0, 13'h0, 0, 0, 13'h0, 0);

    // m0 owns without strobing while m1 waits.
    step(1, 1, 13'h40, 0, 0, 13'h0, 0);
    for (int i = 0; i < 10; i++) step(1, 0, 13'h40, 1, 1, 13'h80, 0);
`ifdef OR1K_EXCEPTION_VECTOR_ARBITER_TIMEOUT_EN
    chk("hold_owner", 32'(grant_o), 32'h2);
`else
    chk("hold_owner", 32'(grant_o), 32'h1);
`endif
    step(0, 0, 13'h0, 0, 0, 13'h0, 0);
    step(0, 0, 13'h0, 0, 0, 13'h0, 0);

    // Random traffic with sticky cyc, random strobes and addresses.
    rc0 = 1'b0; rc1 = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (rc0) rc0 = ($urandom_range(0, 5) != 0); else rc0 = ($urandom_range(0, 2) == 0);
      if (rc1) rc1 = ($urandom_range(0, 5) != 0); else rc1 = ($urandom_range(0, 2) == 0);
      rs0 = rc0 && ($urandom_range(0, 1) == 1);
      rs1 = rc1 && ($urandom_range(0, 1) == 1);
      step(rc0, rs0, 13'($urandom_range(0, 2047) * 4), rc1, rs1,
           13'($urandom_range(0, 2047) * 4), ($urandom_range(0, 63) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/or1k_exception_vector_arbiter.md
Name: or1k_exception_vector_arbiter

Overview:
- Two-master Wishbone arbiter in front of the single procedural exception-vector memory (13-bit address, 32-bit read data, combinational ack).
- Lets two requesters share one vector memory instance, e.g. the instruction buses of two cores, or a core and a debug unit.
- Round-robin grant, held for the whole Wishbone cycle (cyc), with registered grant state.
- Read-only: no write path.

Parameters:
- TIMEOUT_CYCLES, 16, idle-owner timeout in cycles; used only when the optional feature is compiled in; legal range 2..255.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous reset, active-high
- m0_adr_i  input  13  master 0 byte address
- m0_cyc_i  input  1  master 0 bus cycle
- m0_stb_i  input  1  master 0 strobe
- m0_dat_o  output  32  master 0 read data
- m0_ack_o  output  1  master 0 acknowledge
- m1_adr_i  input  13  master 1 byte address
- m1_cyc_i  input  1  master 1 bus cycle
- m1_stb_i  input  1  master 1 strobe
- m1_dat_o  output  32  master 1 read data
- m1_ack_o  output  1  master 1 acknowledge
- s_adr_o  output  13  address to vector memory
- s_cyc_o  output  1  cycle to vector memory
- s_stb_o  output  1  strobe to vector memory
- s_dat_i  input  32  read data from vector memory
- s_ack_i  input  1  ack from vector memory
- grant_o  output  2  one-hot current owner; 2'b00 when idle

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous, active-high.
- Reset values:
  - FSM state = IDLE.
  - Priority pointer = master 0 preferred.
  - grant_o = 0.
  - s_cyc_o = s_stb_o = 0; s_adr_o = 0.
  - m0_ack_o = m1_ack_o = 0.
  - Timeout counter = 0.
- Reset mid-transfer: aborts ownership the same edge; no ack is issued in the cycle after reset.
- FSM states: IDLE, OWN0, OWN1 (registered). grant_o decodes the state.
- IDLE:
  - Only m0_cyc_i: next state OWN0.
  - Only m1_cyc_i: next state OWN1.
  - Both: the master named by the priority pointer wins.
  - Neither: stay in IDLE.
- OWNx:
  - Stay while mx_cyc_i = 1.
  - On mx_cyc_i = 0: if the other master's cyc = 1, move directly to OWN(other) with no IDLE bubble; otherwise go to IDLE.
  - On leaving OWNx, the pointer is set to prefer the other master.
- Slave mux:
  - In OWNx: s_adr_o/s_cyc_o/s_stb_o = mx_adr_i/mx_cyc_i/mx_stb_i.
  - In IDLE: s_cyc_o = s_stb_o = 0 and s_adr_o holds 0.
- Response routing:
  - mx_ack_o = s_ack_i AND (state == OWNx), combinational.
  - m0_dat_o = m1_dat_o = s_dat_i, broadcast. Data is valid only with ack.
- Latency:
  - Request in IDLE at cycle N: grant registered at N+1, slave sees cyc/stb at N+1, first ack at N+1.
  - While owned: one beat per cycle when stb is held, because the memory acks combinationally.
- Non-owner: sees no ack and stalls. Its requests are never lost; it keeps cyc/stb asserted per Wishbone.
- Simultaneous events:
  - Owner drops cyc while the other raises cyc in the same cycle: handover next edge.
  - Both drop: IDLE.
- The arbiter never reorders or splits beats. Address and data widths pass through unchanged.

Optional Feature:
- Macro: OR1K_EXCEPTION_VECTOR_ARBITER_TIMEOUT_EN.
- Defined:
  - 8-bit counter increments each cycle in OWNx with mx_cyc_i = 1, mx_stb_i = 0, and the other master's cyc = 1.
  - Counter clears on any owner strobe, on state change, or when the other master is not requesting.
  - When the counter reaches TIMEOUT_CYCLES-1, the next state is OWN(other), the pointer is updated, and the counter clears.
  - The preempted master stalls until re-granted by normal round-robin.
- Undefined: no counter logic; ownership is released only by cyc deassertion.

Test Plan:
- Reset with both cyc = 0, then m0 single read adr 0x0100: grant_o = 01 one cycle after cyc rises; m0_ack_o = 1 in that cycle; m0_dat_o = s_dat_i; m1_ack_o = 0.
- Both cyc rise in the same cycle after reset: OWN0 first. m0 does 3 beats then drops cyc; next cycle grant_o = 10 with no idle gap; m1 beats acked.
- Fairness: after m1 releases, both request again → m0 granted; m0 then m1 alternate over 4 cycles of contention, with no master starved.
- rst_i asserted while OWN1 with stb = 1: next cycle grant_o = 00, both acks 0, s_cyc_o = 0; after release, m1 (still cyc) re-granted one cycle later.
- Owner keeps stb = 1 across 8 consecutive addresses 0x0000..0x001C: 8 acks in 8 cycles; s_adr_o tracks m0_adr_i exactly.
- TIMEOUT_EN defined with TIMEOUT_CYCLES = 4: m0 owns with cyc = 1, stb = 0 while m1 requests → grant_o switches to 10 after exactly 4 idle cycles. With the macro undefined: m0 holds the grant indefinitely.
